// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset init sequencer and debug tap.
// Optional REGFILE_BYPASS_EN macro: write-first forwarding to the read ports.
module regfile_mp #(
    parameter int XLEN          = 32,
    parameter int NREGS         = 32,
    parameter int NREAD         = 2,
    parameter int HARDWIRE_ZERO = 1,
    localparam int AW           = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  read_en,
    input  logic [NREAD*AW-1:0]   rs,
    output logic [NREAD*XLEN-1:0] r,
    input  logic                  write_en,
    input  logic [AW-1:0]         rd,
    input  logic [XLEN-1:0]       dest_val,
    output logic                  busy,
    input  logic [AW-1:0]         dbg_addr,
    output logic [XLEN-1:0]       dbg_data
);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    state_t          state_nx;
    logic [AW-1:0]   init_cnt;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] rdata [NREAD];
    logic            wr_eff;

    function automatic logic in_range(logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(NREGS);
    endfunction

    function automatic logic is_zero(logic [AW-1:0] a);
        return (HARDWIRE_ZERO != 0) && (a == '0);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == INIT)
                init_cnt <= init_cnt + AW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            INIT: begin
                busy = 1'b1;
                if (init_cnt == AW'(NREGS - 1))
                    state_nx = RUN;
            end
            RUN: state_nx = RUN;
        endcase
    end

    assign wr_eff = (state == RUN) && write_en
                    && in_range(rd) && !is_zero(rd);

    // Storage is never reset; INIT rewrites every entry instead.
    always_ff @(posedge clk) begin
        if (state == INIT)
            regs[init_cnt] <= XLEN'(init_cnt);
        else if (wr_eff)
            regs[rd] <= dest_val;
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          fwd;
        assign a = rs[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign fwd = wr_eff && (a == rd);
`else
        assign fwd = 1'b0;
`endif
        assign rdata[k] = fwd ? dest_val :
                          (in_range(a) && !is_zero(a)) ? regs[a] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= '0;
        end else if (state == RUN && read_en) begin
            for (int k = 0; k < NREAD; k++)
                r[k*XLEN +: XLEN] <= rdata[k];
        end else begin
            r <= '0;
        end
    end

    assign dbg_data = (in_range(dbg_addr) && !is_zero(dbg_addr))
                      ? regs[dbg_addr] : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations driven in parallel,
// checked each cycle against an array model plus literal expectations.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        read_en = 1'b0;
    logic        write_en = 1'b0;
    logic [4:0]  rs_a = '0, rs_b = '0, rs_c = '0;
    logic [4:0]  rd = '0, dbg_addr = '0;
    logic [31:0] dest_val = '0;
    logic [63:0] r0, r1;
    logic [95:0] r2;
    logic [2:0]  busy_v;
    logic [31:0] dbg0, dbg1, dbg2;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_chk = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .HARDWIRE_ZERO(1)) u0 (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .rs({rs_b, rs_a}),
        .r(r0), .write_en(write_en), .rd(rd), .dest_val(dest_val),
        .busy(busy_v[0]), .dbg_addr(dbg_addr), .dbg_data(dbg0));

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .HARDWIRE_ZERO(0)) u1 (
        .clk(clk), .rst_n(rst_n), .read_en(read_en), .rs({rs_b, rs_a}),
        .r(r1), .write_en(write_en), .rd(rd), .dest_val(dest_val),
        .busy(busy_v[1]), .dbg_addr(dbg_addr), .dbg_data(dbg1));

    regfile_mp #(.XLEN(32), .NREGS(24), .NREAD(3), .HARDWIRE_ZERO(1)) u2 (
        .clk(clk), .rst_n(rst_n), .read_en(read_en),
        .rs({rs_c, rs_b, rs_a}),
        .r(r2), .write_en(write_en), .rd(rd), .dest_val(dest_val),
        .busy(busy_v[2]), .dbg_addr(dbg_addr), .dbg_data(dbg2));

    // Model: per-instance contents, init progress and expected r.
    int          nr[3] = '{32, 32, 24};
    int          np[3] = '{2, 2, 3};
    bit          hz[3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] m[3][32];
    bit          kn[3][32];
    int          icnt[3] = '{0, 0, 0};
    logic [31:0] er[3][3] = '{default: '0};

    function automatic logic [4:0] addr(int k);
        return (k == 0) ? rs_a : (k == 1) ? rs_b : rs_c;
    endfunction

    function automatic logic [31:0] mval(int i, logic [4:0] a);
        if (int'(a) >= nr[i] || (hz[i] && a == 0))
            return 32'h0;
        return m[i][a];
    endfunction

    function automatic logic [31:0] dut_r(int i, int k);
        if (i == 0) return r0[k*32 +: 32];
        if (i == 1) return r1[k*32 +: 32];
        return r2[k*32 +: 32];
    endfunction

    function automatic logic [31:0] dut_dbg(int i);
        return (i == 0) ? dbg0 : (i == 1) ? dbg1 : dbg2;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) begin
        for (int i = 0; i < 3; i++) begin
            icnt[i] = 0;
            for (int k = 0; k < 3; k++) er[i][k] = '0;
        end
    end

    always @(posedge clk) begin : mdl
        bit          we;
        logic [31:0] v;
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                m[i][0]  = '0;
                kn[i][0] = 1'b1;
            end else if (icnt[i] < nr[i]) begin
                m[i][icnt[i]]  = icnt[i];
                kn[i][icnt[i]] = 1'b1;
                icnt[i]++;
                for (int k = 0; k < 3; k++) er[i][k] = '0;
            end else begin
                we = write_en && (int'(rd) < nr[i]) && !(hz[i] && rd == 0);
                for (int k = 0; k < np[i]; k++) begin
                    v = read_en ? mval(i, addr(k)) : 32'h0;
`ifdef REGFILE_BYPASS_EN
                    if (read_en && we && addr(k) == rd) v = dest_val;
`endif
                    er[i][k] = v;
                end
                if (we) begin
                    m[i][rd]  = dest_val;
                    kn[i][rd] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("busy_u%0d", i), {31'b0, busy_v[i]},
                      (icnt[i] < nr[i]) ? 32'd1 : 32'd0);
                for (int k = 0; k < np[i]; k++)
                    check($sformatf("r_u%0d_p%0d", i, k), dut_r(i, k), er[i][k]);
                if (int'(dbg_addr) >= nr[i] || (hz[i] && dbg_addr == 0)
                    || kn[i][dbg_addr])
                    check($sformatf("dbg_u%0d", i), dut_dbg(i),
                          mval(i, dbg_addr));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_init(int e0, int e1, int e2);
        int c[3] = '{0, 0, 0};
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (busy_v[i]) c[i]++;
        end
        check("busy_cycles_u0", c[0], e0);
        check("busy_cycles_u1", c[1], e1);
        check("busy_cycles_u2", c[2], e2);
    endtask

    logic [31:0] hz_exp;

    initial begin
        run_chk = 1;
        cyc();
        cyc();
        check("rst_busy", {29'b0, busy_v}, 32'd7);
        check("rst_r0", r0[31:0], 32'h0);
        check("rst_r2", r2[95:64], 32'h0);

        rst_n = 1'b1;
        wait_init(32, 32, 24);

        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            check($sformatf("init_dbg_u0_%0d", i), dbg0, i);
            check($sformatf("init_dbg_u1_%0d", i), dbg1, i);
            check($sformatf("init_dbg_u2_%0d", i), dbg2, (i < 24) ? i : 0);
        end
        cyc();

        write_en = 1; rd = 5; dest_val = 32'hDEADBEEF;
        cyc();
        write_en = 0; read_en = 1; rs_a = 5; rs_b = 31; rs_c = 23;
        cyc();
        check("rw_u0_p0", r0[31:0], 32'hDEADBEEF);
        check("rw_u0_p1", r0[63:32], 32'd31);
        check("rw_u2_p1", r2[63:32], 32'h0);
        check("rw_u2_p2", r2[95:64], 32'd23);
        read_en = 0;
        cyc();
        check("rd_off_u0", r0[31:0], 32'h0);

        write_en = 1; rd = 0; dest_val = 32'h1234;
        cyc();
        write_en = 0; read_en = 1; rs_a = 0; dbg_addr = 0;
        cyc();
        read_en = 0;
        check("zero_r_u0", r0[31:0], 32'h0);
        check("zero_r_u1", r1[31:0], 32'h1234);
        check("zero_dbg_u0", dbg0, 32'h0);
        check("zero_dbg_u1", dbg1, 32'h1234);

`ifdef REGFILE_BYPASS_EN
        hz_exp = 32'hA5A5A5A5;
`else
        hz_exp = 32'd7;
`endif
        write_en = 1; rd = 7; dest_val = 32'hA5A5A5A5;
        read_en = 1; rs_a = 7;
        cyc();
        write_en = 0;
        check("haz_u0", r0[31:0], hz_exp);
        check("haz_u2", r2[31:0], hz_exp);
        cyc();
        read_en = 0;
        check("haz_after_u0", r0[31:0], 32'hA5A5A5A5);
        check("haz_after_u1", r1[31:0], 32'hA5A5A5A5);

        write_en = 1; rd = 30; dest_val = 32'h77;
        cyc();
        write_en = 0; read_en = 1; rs_a = 23; rs_b = 24; rs_c = 31;
        cyc();
        read_en = 0;
        check("np2_p0", r2[31:0], 32'd23);
        check("np2_p1", r2[63:32], 32'h0);
        check("np2_p2", r2[95:64], 32'h0);
        dbg_addr = 23;
        #1 check("np2_dbg23", dbg2, 32'd23);
        dbg_addr = 30;
        #1 check("np2_dbg30_u2", dbg2, 32'h0);
        check("np2_dbg30_u0", dbg0, 32'h77);
        cyc();

        write_en = 1; rd = 3; dest_val = 32'hFF;
        read_en = 1; rs_a = 5; rs_b = 3;
        cyc();
        write_en = 0; read_en = 0;
        check("pre_rst_r", r0[31:0], 32'hDEADBEEF);
        rst_n = 1'b0;
        #1;
        check("async_r_u0", r0[31:0], 32'h0);
        check("async_r_u2", r2[31:0], 32'h0);
        check("async_busy", {29'b0, busy_v}, 32'd7);
        cyc();
        rst_n = 1'b1;
        write_en = 1; rd = 3; dest_val = 32'hFF; dbg_addr = 3;
        for (int n = 0; n < 10; n++) cyc();
        check("init_wr_ign_u0", dbg0, 32'd3);
        check("init_wr_ign_u1", dbg1, 32'd3);
        rst_n = 1'b0;
        #1 check("async_busy2", {29'b0, busy_v}, 32'd7);
        cyc();
        write_en = 0;
        rst_n = 1'b1;
        wait_init(32, 32, 24);
        read_en = 1; rs_a = 3;
        cyc();
        read_en = 0;
        check("reinit_r3_u0", r0[31:0], 32'd3);
        check("reinit_r3_u1", r1[31:0], 32'd3);
        check("reinit_r3_u2", r2[31:0], 32'd3);
        cyc();
        cyc();

        run_chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
